gbfact_sram_hold: RTL and testbench

- Global-buffer factor storage block: a 256-entry x 96-bit single-port SRAM behavioural model with 12 byte-lane write enables.
- Adds a one-cycle read-enable delay stage and a read-data hold register, so `data_out` stays stable after a read until the next read completes.
- Sits between the GB controller (addresses, enables) and the PE-side consumers of factor words.

---
 rtl/gbfact_sram_hold_if.sv | 28 ++
 rtl/gbfact_sram_hold.sv | 95 +++++++++
 tb/tb_gbfact_sram_hold.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/gbfact_sram_hold_if.sv
// Bus between the GB controller and the factor-storage SRAM block.
// The controller side drives addresses, enables, lane mask and write data;
// the storage side returns the held read word.
interface gbfact_sram_hold_if #(
  parameter int DEPTH_BIT = 8,
  parameter int LANES     = 12,
  parameter int WIDTH     = 96
);
  logic [DEPTH_BIT-1:0] addr_r;
  logic [DEPTH_BIT-1:0] addr_w;
  logic                 read_en;
  logic                 write_en;
  logic [LANES-1:0]     wmask;
  logic [WIDTH-1:0]     data_in;
  logic [WIDTH-1:0]     data_out;

  // GB controller side
  modport master (
    output addr_r, addr_w, read_en, write_en, wmask, data_in,
    input  data_out
  );

  // Storage side
  modport slave (
    input  addr_r, addr_w, read_en, write_en, wmask, data_in,
    output data_out
  );
endinterface

// File: rtl/gbfact_sram_hold.sv
// Global-buffer factor storage: 2**DEPTH_BIT x WIDTH single-port SRAM model
// with LANES byte-lane write enables, a one-cycle read-valid delay and a
// hold register so data_out keeps the last read word until the next read
// completes. WIDTH must equal 8*LANES.
module gbfact_sram_hold #(
  parameter int DEPTH_BIT = 8,
  parameter int LANES     = 12,
  parameter int WIDTH     = 96
) (
  input logic                clk,
  input logic                reset,
  gbfact_sram_hold_if.slave  bus
);

  localparam int DEPTH = 2 ** DEPTH_BIT;

  // Single physical port of the macro.
  logic [DEPTH_BIT-1:0] addr_int;
  logic                 csb;        // active-low chip select
  logic [LANES-1:0]     web;        // active-low per-lane write enable
  logic                 wr_fire;    // at least one lane is written this edge
  logic                 rd_fire;    // a real read is performed this edge
  logic [WIDTH-1:0]     wr_word;    // stored word with enabled lanes replaced

  logic [WIDTH-1:0] mem [DEPTH];

  // Macro output register, read-valid delay stage, hold register.
  logic [WIDTH-1:0] do_q,   do_d;
  logic             rd_q,   rd_d;
  logic [WIDTH-1:0] hold_q, hold_d;

  // Port mux and macro control strobes; a write always wins the port.
  always_comb begin
    addr_int = bus.write_en ? bus.addr_w : bus.addr_r;
    csb      = ~(bus.read_en | bus.write_en);
    web      = ~({LANES{bus.write_en}} & bus.wmask);
    wr_fire  = ~csb & ~(&web);
    rd_fire  = ~csb & ~bus.write_en;
  end

  // Merge incoming lanes into the addressed word; untouched lanes keep
  // their stored bytes.
  always_comb begin
    wr_word = mem[addr_int];
    for (int i = 0; i < LANES; i++) begin
      if (!web[i]) begin
        wr_word[8*i +: 8] = bus.data_in[8*i +: 8];
      end
    end
  end

  // Memory array update; writes proceed even while reset is asserted.
  // NOTE: the storage array has no reset -- real SRAM macros cannot be
  // cleared in one cycle, and a reset here would turn it into flops.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[addr_int] <= wr_word;
    end
  end

  // Next state for DO, read-valid delay and hold register.
  // NOTE: every variable gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    do_d   = do_q;
    rd_d   = rd_fire;
    hold_d = hold_q;
    if (rd_fire) begin
      do_d = mem[addr_int];
    end
    if (rd_q) begin
      hold_d = do_q;
    end
  end

  // State registers; reset clears the read path and discards a read issued
  // in the reset cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      do_q   <= '0;
      rd_q   <= 1'b0;
      hold_q <= '0;
    end else begin
      do_q   <= do_d;
      rd_q   <= rd_d;
      hold_q <= hold_d;
    end
  end

  // Fresh word in the cycle after a read, otherwise the held word.
  assign bus.data_out = rd_q ? do_q : hold_q;

endmodule

// File: tb/tb_gbfact_sram_hold.sv
// Directed self-checking bench for gbfact_sram_hold.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_gbfact_sram_hold;

  localparam int DEPTH_BIT = 8;
  localparam int LANES     = 12;
  localparam int WIDTH     = 96;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  gbfact_sram_hold_if #(.DEPTH_BIT(DEPTH_BIT), .LANES(LANES), .WIDTH(WIDTH)) bus ();

  gbfact_sram_hold #(.DEPTH_BIT(DEPTH_BIT), .LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [WIDTH-1:0] W_BASIC = 96'h0123456789AB0123456789AB;
  localparam logic [WIDTH-1:0] W_ONES  = {12{8'hFF}};
  localparam logic [WIDTH-1:0] W_LANE0 = {{11{8'hFF}}, 8'h00};
  localparam logic [WIDTH-1:0] W_11    = {12{8'h11}};
  localparam logic [WIDTH-1:0] W_22    = {12{8'h22}};
  localparam logic [WIDTH-1:0] W_33    = {12{8'h33}};
  localparam logic [WIDTH-1:0] W_NEW4  = 96'hDEADBEEFCAFEF00D12345678;
  localparam logic [WIDTH-1:0] W_AA    = {12{8'hAA}};
  localparam logic [WIDTH-1:0] W_55    = {12{8'h55}};
  localparam logic [WIDTH-1:0] W_RST   = 96'h0F1E2D3C4B5A69788796A5B4;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.read_en  = 1'b0;
    bus.write_en = 1'b0;
    bus.wmask    = '0;
  endtask

  // One write cycle; inputs return to idle afterwards.
  task automatic wr(input logic [DEPTH_BIT-1:0] a, input logic [WIDTH-1:0] d,
                    input logic [LANES-1:0] m);
    bus.write_en = 1'b1;
    bus.addr_w   = a;
    bus.data_in  = d;
    bus.wmask    = m;
    tick();
    idle();
  endtask

  // One read cycle; after return data_out must show the word.
  task automatic rd(input logic [DEPTH_BIT-1:0] a);
    bus.read_en = 1'b1;
    bus.addr_r  = a;
    tick();
    idle();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset        = 1'b1;
    bus.addr_r   = '0;
    bus.addr_w   = '0;
    bus.data_in  = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    check("reset_out", bus.data_out, '0);

    // Basic write then read next cycle; word holds through idle.
    wr(8'd5, W_BASIC, 12'hFFF);
    rd(8'd5);
    check("basic_rd", bus.data_out, W_BASIC);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("basic_hold%0d", i), bus.data_out, W_BASIC);
    end

    // Byte lanes: only lane 0 cleared; zero mask is a no-op.
    wr(8'd9, W_ONES, 12'hFFF);
    wr(8'd9, '0, 12'h001);
    rd(8'd9);
    check("lane0", bus.data_out, W_LANE0);
    wr(8'd9, '0, 12'h000);
    rd(8'd9);
    check("mask_zero", bus.data_out, W_LANE0);

    // Back-to-back reads, one word per cycle, then hold.
    wr(8'd0, W_11, 12'hFFF);
    wr(8'd1, W_22, 12'hFFF);
    wr(8'd2, W_33, 12'hFFF);
    bus.read_en = 1'b1;
    bus.addr_r  = 8'd0;
    tick();
    check("b2b_0", bus.data_out, W_11);
    bus.addr_r = 8'd1;
    tick();
    check("b2b_1", bus.data_out, W_22);
    bus.addr_r = 8'd2;
    tick();
    check("b2b_2", bus.data_out, W_33);
    idle();
    tick();
    check("b2b_hold0", bus.data_out, W_33);
    tick();
    check("b2b_hold1", bus.data_out, W_33);

    // Write priority: simultaneous read dropped, write lands.
    bus.read_en  = 1'b1;
    bus.write_en = 1'b1;
    bus.addr_r   = 8'd3;
    bus.addr_w   = 8'd4;
    bus.data_in  = W_NEW4;
    bus.wmask    = 12'hFFF;
    tick();
    idle();
    check("prio_keep0", bus.data_out, W_33);
    tick();
    check("prio_keep1", bus.data_out, W_33);
    rd(8'd4);
    check("prio_new", bus.data_out, W_NEW4);

    // Hold across writes to the same address.
    wr(8'd7, W_AA, 12'hFFF);
    rd(8'd7);
    check("hold_rd", bus.data_out, W_AA);
    wr(8'd7, W_55, 12'hFFF);
    check("hold_wr0", bus.data_out, W_AA);
    tick();
    check("hold_wr1", bus.data_out, W_AA);

    // Reset mid-operation: read in reset cycle discarded, write kept.
    reset        = 1'b1;
    bus.read_en  = 1'b1;
    bus.addr_r   = 8'd7;
    bus.write_en = 1'b0;
    tick();
    bus.read_en  = 1'b0;
    bus.write_en = 1'b1;
    bus.addr_w   = 8'd10;
    bus.data_in  = W_RST;
    bus.wmask    = 12'hFFF;
    tick();
    reset = 1'b0;
    idle();
    check("rst_clear0", bus.data_out, '0);
    tick();
    check("rst_clear1", bus.data_out, '0);
    rd(8'd7);
    check("rst_mem7", bus.data_out, W_55);
    rd(8'd10);
    check("rst_wr10", bus.data_out, W_RST);
    tick();
    check("rst_hold10", bus.data_out, W_RST);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
